debug_snapshot_serializer: RTL and testbench

- Parametrised debug-export engine for the pipelined CPU.
- On a capture strobe it snapshots N_WORDS pipeline-state words (control, ID/EX, EX/MEM, MEM/WB, WB, PC, ...). It then streams the selected words as a framed byte stream over a valid/ready interface into the UART TX.
- Generalises the fixed-width debug buses in four ways: configurable word count and width, a per-word select mask, a checksum, and overrun detection.

---
 rtl/debug_snapshot_serializer.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_debug_snapshot_serializer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_snapshot_serializer.sv
// -----------------------------------------------------------------------------
// debug_snapshot_serializer
//
// Debug-export engine for the pipelined CPU. A capture strobe latches a
// snapshot of N_WORDS pipeline-state words together with a per-word select
// mask. The selected words are then streamed to the UART TX over a
// valid/ready byte interface as one frame:
//
//     HDR_BYTE, CNT, data bytes..., CSUM
//
//   CNT  = number of selected words (popcount of the latched mask)
//   data = each selected word in ascending index order, least-significant
//          byte first, NB_WORD/8 bytes per word
//   CSUM = XOR of CNT and every data byte (the header is not included)
//
// A capture request that arrives while a frame is in flight (including the
// DONE cycle) is ignored and raises the sticky o_overrun flag. o_overrun is
// cleared by i_clear; if a new overrun happens in the same cycle, the set wins.
//
// Ports:
//   clk          in   rising-edge system clock
//   i_reset      in   asynchronous active-low reset
//   i_capture    in   single-cycle snapshot request
//   i_snapshot   in   N_WORDS*NB_WORD debug words, word k at [k*NB_WORD +: NB_WORD]
//   i_word_mask  in   N_WORDS select bits, sampled together with i_snapshot
//   i_clear      in   clears o_overrun
//   o_tx_data    out  byte presented to the UART TX
//   o_tx_valid   out  o_tx_data is valid
//   i_tx_ready   in   UART TX accepts the byte this cycle
//   o_busy       out  frame in progress
//   o_done       out  one-cycle pulse when a frame completes
//   o_overrun    out  sticky flag: capture requested while busy
//
// All outputs are registered. The output register is loaded from the
// next-state decode, so o_tx_valid rises in the cycle right after the
// capture edge and stays stable while the TX back-pressures.
// -----------------------------------------------------------------------------
module debug_snapshot_serializer #(
    parameter int          N_WORDS  = 8,
    parameter int          NB_WORD  = 32,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic                       clk,
    input  logic                       i_reset,
    input  logic                       i_capture,
    input  logic [N_WORDS*NB_WORD-1:0] i_snapshot,
    input  logic [N_WORDS-1:0]         i_word_mask,
    input  logic                       i_clear,
    output logic [7:0]                 o_tx_data,
    output logic                       o_tx_valid,
    input  logic                       i_tx_ready,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_overrun
);

    localparam int NB_BYTES = NB_WORD / 8;
    localparam int WIDX_W   = $clog2(N_WORDS + 1);
    localparam int BIDX_W   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    // Lookup tables are padded to a power of two so every index value is legal.
    localparam int WSLOTS   = 1 << WIDX_W;
    localparam int BSLOTS   = 1 << BIDX_W;

    localparam logic [WIDX_W-1:0] WIDX_ZERO = {WIDX_W{1'b0}};
    localparam logic [WIDX_W-1:0] WIDX_ONE  = WIDX_W'(1);
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(N_WORDS - 1);
    localparam logic [WIDX_W-1:0] WORD_END  = WIDX_W'(N_WORDS);
    localparam logic [BIDX_W-1:0] BIDX_ZERO = {BIDX_W{1'b0}};
    localparam logic [BIDX_W-1:0] BIDX_ONE  = BIDX_W'(1);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NB_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_CNT  = 3'd2,
        ST_SCAN = 3'd3,
        ST_DATA = 3'd4,
        ST_CSUM = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    // Number of set bits in the word mask, as the 8-bit CNT field.
    function automatic logic [7:0] popcount8(input logic [N_WORDS-1:0] v);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < N_WORDS; k++) begin
            c = c + {7'b0000000, v[k]};
        end
        return c;
    endfunction

    // Registers
    state_t                       state_r;
    logic [WIDX_W-1:0]            word_idx_r;
    logic [BIDX_W-1:0]            byte_idx_r;
    logic [N_WORDS*NB_WORD-1:0]   snap_r;
    logic [N_WORDS-1:0]           mask_r;
    logic [7:0]                   csum_r;
    logic                         overrun_r;
    logic [7:0]                   tx_data_r;
    logic                         tx_valid_r;
    logic                         busy_r;
    logic                         done_r;

    // Next-state values
    state_t                       state_s;
    logic [WIDX_W-1:0]            word_idx_s;
    logic [BIDX_W-1:0]            byte_idx_s;
    logic [N_WORDS*NB_WORD-1:0]   snap_s;
    logic [N_WORDS-1:0]           mask_s;
    logic [7:0]                   csum_s;
    logic                         overrun_s;
    logic [7:0]                   tx_data_s;
    logic                         tx_valid_s;
    logic                         busy_s;
    logic                         done_s;

    // Datapath helpers
    logic                         xfer_s;
    logic [7:0]                   cnt_s;
    logic [WSLOTS-1:0]            mask_pad_s;
    logic [NB_WORD-1:0]           word_arr_s [WSLOTS];
    logic [NB_WORD-1:0]           cur_word_s;
    logic [7:0]                   byte_arr_s [BSLOTS];
    logic [7:0]                   byte_sel_s;

    assign xfer_s = tx_valid_r & i_tx_ready;
    assign cnt_s  = popcount8(mask_r);

    assign o_tx_data  = tx_data_r;
    assign o_tx_valid = tx_valid_r;
    assign o_busy     = busy_r;
    assign o_done     = done_r;
    assign o_overrun  = overrun_r;

    // Zero-extend the latched mask so the scan index can never select out of range.
    always_comb begin
        mask_pad_s                = {WSLOTS{1'b0}};
        mask_pad_s[N_WORDS-1:0]   = mask_r;
    end

    // Split the latched snapshot into words; padding slots read as zero.
    always_comb begin
        for (int k = 0; k < WSLOTS; k++) begin
            word_arr_s[k] = {NB_WORD{1'b0}};
        end
        for (int k = 0; k < N_WORDS; k++) begin
            word_arr_s[k] = snap_r[k*NB_WORD +: NB_WORD];
        end
    end

    // Pick the byte that the next cycle will present (indexed by next-state counters).
    always_comb begin
        cur_word_s = word_arr_s[word_idx_s];
        for (int b = 0; b < BSLOTS; b++) begin
            byte_arr_s[b] = 8'h00;
        end
        for (int b = 0; b < NB_BYTES; b++) begin
            byte_arr_s[b] = cur_word_s[b*8 +: 8];
        end
        byte_sel_s = byte_arr_s[byte_idx_s];
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r    <= ST_IDLE;
            word_idx_r <= WIDX_ZERO;
            byte_idx_r <= BIDX_ZERO;
            snap_r     <= {(N_WORDS*NB_WORD){1'b0}};
            mask_r     <= {N_WORDS{1'b0}};
            csum_r     <= 8'h00;
            overrun_r  <= 1'b0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            word_idx_r <= word_idx_s;
            byte_idx_r <= byte_idx_s;
            snap_r     <= snap_s;
            mask_r     <= mask_s;
            csum_r     <= csum_s;
            overrun_r  <= overrun_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    // Next-state, counter, checksum and overrun logic.
    always_comb begin
        state_s    = state_r;
        word_idx_s = word_idx_r;
        byte_idx_s = byte_idx_r;
        snap_s     = snap_r;
        mask_s     = mask_r;
        csum_s     = csum_r;

        case (state_r)
            ST_IDLE: begin
                if (i_capture) begin
                    snap_s     = i_snapshot;
                    mask_s     = i_word_mask;
                    word_idx_s = WIDX_ZERO;
                    byte_idx_s = BIDX_ZERO;
                    state_s    = ST_HDR;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (xfer_s) begin
                    state_s = ST_CNT;
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_CNT: begin
                if (xfer_s) begin
                    csum_s     = cnt_s;
                    word_idx_s = WIDX_ZERO;
                    byte_idx_s = BIDX_ZERO;
                    state_s    = ST_SCAN;
                end else begin
                    state_s    = ST_CNT;
                end
            end
            ST_SCAN: begin
                // One idle cycle per examined index. A clear bit at the last
                // index jumps straight to CSUM so an empty mask costs exactly
                // N_WORDS scan cycles.
                if (word_idx_r == WORD_END) begin
                    state_s    = ST_CSUM;
                end else if (mask_pad_s[word_idx_r]) begin
                    byte_idx_s = BIDX_ZERO;
                    state_s    = ST_DATA;
                end else if (word_idx_r == LAST_WORD) begin
                    word_idx_s = WORD_END;
                    state_s    = ST_CSUM;
                end else begin
                    word_idx_s = word_idx_r + WIDX_ONE;
                    state_s    = ST_SCAN;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    csum_s = csum_r ^ tx_data_r;
                    if (byte_idx_r == LAST_BYTE) begin
                        word_idx_s = word_idx_r + WIDX_ONE;
                        byte_idx_s = BIDX_ZERO;
                        state_s    = ST_SCAN;
                    end else begin
                        byte_idx_s = byte_idx_r + BIDX_ONE;
                        state_s    = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (xfer_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CSUM;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Sticky overrun: a capture outside IDLE sets it, and set beats clear.
        if (i_capture && (state_r != ST_IDLE)) begin
            overrun_s = 1'b1;
        end else if (i_clear) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end
    end

    // Output decode from the next state, loaded into the output registers.
    always_comb begin
        tx_valid_s = 1'b0;
        tx_data_s  = 8'h00;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        case (state_s)
            ST_IDLE: begin
                tx_valid_s = 1'b0;
            end
            ST_HDR: begin
                tx_valid_s = 1'b1;
                tx_data_s  = HDR_BYTE;
                busy_s     = 1'b1;
            end
            ST_CNT: begin
                tx_valid_s = 1'b1;
                tx_data_s  = cnt_s;
                busy_s     = 1'b1;
            end
            ST_SCAN: begin
                busy_s     = 1'b1;
            end
            ST_DATA: begin
                tx_valid_s = 1'b1;
                tx_data_s  = byte_sel_s;
                busy_s     = 1'b1;
            end
            ST_CSUM: begin
                tx_valid_s = 1'b1;
                tx_data_s  = csum_s;
                busy_s     = 1'b1;
            end
            ST_DONE: begin
                done_s     = 1'b1;
            end
            default: begin
                tx_valid_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_debug_snapshot_serializer.sv
module tb_debug_snapshot_serializer;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             i_reset;
    logic             i_capture;
    logic [N*W-1:0]   i_snapshot;
    logic [N-1:0]     i_word_mask;
    logic             i_clear;
    logic [7:0]       o_tx_data;
    logic             o_tx_valid;
    logic             i_tx_ready;
    logic             o_busy;
    logic             o_done;
    logic             o_overrun;

    logic [7:0]       exp_q [$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               done_cnt = 0;
    int               gap_cnt  = 0;
    int               pop_cnt  = 0;
    logic             prev_hold = 1'b0;
    logic [7:0]       prev_data = 8'h00;

    debug_snapshot_serializer #(
        .N_WORDS  (N),
        .NB_WORD  (W),
        .HDR_BYTE (8'hA5)
    ) dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_capture   (i_capture),
        .i_snapshot  (i_snapshot),
        .i_word_mask (i_word_mask),
        .i_clear     (i_clear),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_overrun   (o_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic push_frame_t1();
        push(8'hA5); push(8'h02);
        push(8'h44); push(8'h33); push(8'h22); push(8'h11);
        push(8'hDD); push(8'hCC); push(8'hBB); push(8'hAA);
        push(8'h46);
    endtask

    task automatic capture();
        i_capture = 1'b1;
        tick();
        i_capture = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start;
        int k;
        start = done_cnt;
        k = 0;
        while (done_cnt == start && k < 300) begin
            tick();
            k++;
        end
        check({name, "_timeout"}, 32'(done_cnt != start), 32'd1);
        repeat (3) tick();
        check({name, "_done_once"}, 32'(done_cnt - start), 32'd1);
        check({name, "_all_bytes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_pops(input string name, input int start, input int want);
        int k;
        k = 0;
        while ((pop_cnt - start) < want && k < 100) begin
            tick();
            k++;
        end
        check({name, "_pop_timeout"}, 32'((pop_cnt - start) >= want), 32'd1);
    endtask

    // Monitor: pops the scoreboard on every transfer and checks hold stability.
    always @(negedge clk) begin
        if (!i_reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(o_tx_valid), 32'd1);
                check("hold_data", 32'(o_tx_data), 32'(prev_data));
            end
            if (o_tx_valid && i_tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(o_tx_data), 32'h100);
                end else begin
                    check("frame_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
                end
                pop_cnt++;
            end
            if (o_done) begin
                done_cnt++;
                check("busy_at_done", 32'(o_busy), 32'd0);
            end
            if (o_busy && !o_tx_valid) begin
                gap_cnt++;
            end
            prev_hold = o_tx_valid && !i_tx_ready;
            prev_data = o_tx_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        i_reset     = 1'b0;
        i_capture   = 1'b0;
        i_clear     = 1'b0;
        i_tx_ready  = 1'b1;
        i_snapshot  = {(N*W){1'b0}};
        i_word_mask = 4'b0000;
        repeat (2) tick();

        // Reset state
        check("rst_valid", 32'(o_tx_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_overrun", 32'(o_overrun), 32'd0);
        check("rst_data", 32'(o_tx_data), 32'd0);
        i_reset = 1'b1;
        tick();

        // Two words selected, full-rate TX; inputs scrambled after capture
        i_snapshot  = {32'h55667788, 32'h99000011, 32'hAABBCCDD, 32'h11223344};
        i_word_mask = 4'b0011;
        push_frame_t1();
        capture();
        check("t1_first_valid", 32'(o_tx_valid), 32'd1);
        check("t1_first_busy", 32'(o_busy), 32'd1);
        i_snapshot  = {4{32'hDEADBEEF}};
        i_word_mask = 4'b1111;
        wait_done("t1");

        // Empty mask: header, zero count, zero checksum, N scan gaps
        i_word_mask = 4'b0000;
        push(8'hA5); push(8'h00); push(8'h00);
        gap_cnt = 0;
        capture();
        wait_done("t2");
        check("t2_scan_gaps", 32'(gap_cnt), 32'd4);

        // Back-pressure on the header for 5 cycles
        i_snapshot  = {32'h0, 32'h0, 32'h0, 32'h11223344};
        i_word_mask = 4'b0001;
        push(8'hA5); push(8'h01);
        push(8'h44); push(8'h33); push(8'h22); push(8'h11);
        push(8'h45);
        i_tx_ready = 1'b0;
        capture();
        for (int i = 0; i < 5; i++) begin
            check("t3_hdr_valid", 32'(o_tx_valid), 32'd1);
            check("t3_hdr_data", 32'(o_tx_data), 32'hA5);
            if (i < 4) begin
                tick();
            end
        end
        i_tx_ready = 1'b1;
        wait_done("t3");

        // Overrun: capture mid-DATA, then clear+capture together, then clear
        i_snapshot  = {32'h0, 32'h0, 32'hAABBCCDD, 32'h11223344};
        i_word_mask = 4'b0011;
        push_frame_t1();
        start = pop_cnt;
        capture();
        wait_pops("t4", start, 3);
        i_snapshot  = {4{32'h01020304}};
        i_word_mask = 4'b1111;
        i_capture   = 1'b1;
        tick();
        i_capture   = 1'b0;
        check("t4_overrun_set", 32'(o_overrun), 32'd1);
        i_capture = 1'b1;
        i_clear   = 1'b1;
        tick();
        i_capture = 1'b0;
        i_clear   = 1'b0;
        check("t4_set_wins", 32'(o_overrun), 32'd1);
        wait_done("t4");
        check("t4_sticky", 32'(o_overrun), 32'd1);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("t4_cleared", 32'(o_overrun), 32'd0);

        // Asynchronous reset during DATA, then a clean frame
        i_snapshot  = {32'h0, 32'h0, 32'hAABBCCDD, 32'h11223344};
        i_word_mask = 4'b0011;
        push_frame_t1();
        start = pop_cnt;
        capture();
        wait_pops("t5", start, 3);
        #2;
        i_reset = 1'b0;
        #1;
        check("t5_rst_valid", 32'(o_tx_valid), 32'd0);
        check("t5_rst_busy", 32'(o_busy), 32'd0);
        check("t5_rst_done", 32'(o_done), 32'd0);
        exp_q.delete();
        repeat (2) tick();
        i_reset = 1'b1;
        tick();
        push_frame_t1();
        capture();
        check("t5_restart_hdr", 32'(o_tx_data), 32'hA5);
        wait_done("t5");

        // Top word only with random back-pressure
        i_snapshot  = {32'h000000FF, 32'h12345678, 32'hAABBCCDD, 32'h11223344};
        i_word_mask = 4'b1000;
        push(8'hA5); push(8'h01);
        push(8'hFF); push(8'h00); push(8'h00); push(8'h00);
        push(8'hFE);
        start = done_cnt;
        i_tx_ready = 1'($urandom_range(0, 1));
        capture();
        for (int k = 0; k < 400 && done_cnt == start; k++) begin
            i_tx_ready = 1'($urandom_range(0, 1));
            tick();
        end
        i_tx_ready = 1'b1;
        check("t6_timeout", 32'(done_cnt != start), 32'd1);
        repeat (3) tick();
        check("t6_done_once", 32'(done_cnt - start), 32'd1);
        check("t6_all_bytes", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
